// File: rtl/hazard_pkg.sv
// Shared encodings and scoreboard slot type for the five-stage pipeline hazard unit.
package hazard_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] WR_RD   = 2'b00;
    localparam logic [1:0] WR_RT   = 2'b01;
    localparam logic [1:0] WR_RA   = 2'b10;
    localparam logic [1:0] WR_NONE = 2'b11;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic       valid;
        logic [4:0] waddr;
        logic [1:0] tnew;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, waddr: 5'd0, tnew: 2'd0};

    // A write to $0 or no write at all resolves to $0, which the slot marks invalid.
    function automatic logic [4:0] resolve_waddr(input logic [1:0] wr_sel,
                                                 input logic [4:0] rd,
                                                 input logic [4:0] rt);
        logic [4:0] addr;
        case (wr_sel)
            WR_RD:   addr = rd;
            WR_RT:   addr = rt;
            WR_RA:   addr = REG_RA;
            default: addr = REG_ZERO;
        endcase
        return addr;
    endfunction

    function automatic logic [1:0] tnew_step(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_operand_check.sv
// Resolves one source operand against the E/M/W producers: stall request and forward select.
module hazard_operand_check
    import hazard_pkg::*;
(
    input  logic [4:0] i_addr,
    input  logic [1:0] i_tuse,
    input  slot_t      i_slot_e,
    input  slot_t      i_slot_m,
    input  slot_t      i_slot_w,
    output logic       o_stall_req,
    output logic [1:0] o_sel
);

    logic       w_hit;
    logic [1:0] w_stage;
    logic [1:0] w_tnew;

    // Youngest matching producer wins, so E is searched before M before W.
    always_comb begin
        w_hit   = 1'b0;
        w_stage = FWD_RF;
        w_tnew  = 2'd0;
        if (i_slot_e.valid && (i_slot_e.waddr == i_addr)) begin
            w_hit   = 1'b1;
            w_stage = FWD_E;
            w_tnew  = i_slot_e.tnew;
        end else if (i_slot_m.valid && (i_slot_m.waddr == i_addr)) begin
            w_hit   = 1'b1;
            w_stage = FWD_M;
            w_tnew  = i_slot_m.tnew;
        end else if (i_slot_w.valid && (i_slot_w.waddr == i_addr)) begin
            w_hit   = 1'b1;
            w_stage = FWD_W;
            w_tnew  = i_slot_w.tnew;
        end
    end

    always_comb begin
        o_stall_req = 1'b0;
        o_sel       = FWD_RF;
        if ((i_addr != REG_ZERO) && (i_tuse != TUSE_NONE) && w_hit) begin
            if (w_tnew > i_tuse) begin
                o_stall_req = 1'b1;
            end else if (w_tnew == 2'd0) begin
                o_sel = w_stage;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// E/M/W producer scoreboard with D-stage stall generation and D/E forwarding selects.
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] d_rs_addr,
    input  logic [4:0] d_rt_addr,
    input  logic [4:0] d_rd_addr,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [1:0] d_wr_sel,
    input  logic [1:0] d_tnew_e,
    output logic       stall,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e
);

    slot_t      r_slot_e;
    slot_t      r_slot_m;
    slot_t      r_slot_w;
    logic [4:0] r_e_rs_addr;
    logic [4:0] r_e_rt_addr;

    slot_t      w_d_entry;
    logic       w_stall_rs;
    logic       w_stall_rt;
    logic       w_unused_e_rs_stall;
    logic       w_unused_e_rt_stall;

    always_comb begin
        w_d_entry       = SLOT_EMPTY;
        w_d_entry.waddr = resolve_waddr(d_wr_sel, d_rd_addr, d_rt_addr);
        w_d_entry.valid = (w_d_entry.waddr != REG_ZERO);
        w_d_entry.tnew  = d_tnew_e;
    end

    assign stall = w_stall_rs | w_stall_rt;

    // Stage shift: W takes M (result always ready by W), M takes E with one cycle of
    // progress, E takes the D instruction or a bubble while D is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_e    <= SLOT_EMPTY;
            r_slot_m    <= SLOT_EMPTY;
            r_slot_w    <= SLOT_EMPTY;
            r_e_rs_addr <= REG_ZERO;
            r_e_rt_addr <= REG_ZERO;
        end else begin
            r_slot_w.valid <= r_slot_m.valid;
            r_slot_w.waddr <= r_slot_m.waddr;
            r_slot_w.tnew  <= 2'd0;
            r_slot_m.valid <= r_slot_e.valid;
            r_slot_m.waddr <= r_slot_e.waddr;
            r_slot_m.tnew  <= tnew_step(r_slot_e.tnew);
            if (stall) begin
                r_slot_e    <= SLOT_EMPTY;
                r_e_rs_addr <= REG_ZERO;
                r_e_rt_addr <= REG_ZERO;
            end else begin
                r_slot_e    <= w_d_entry;
                r_e_rs_addr <= d_rs_addr;
                r_e_rt_addr <= d_rt_addr;
            end
        end
    end

    hazard_operand_check u_chk_rs_d (
        .i_addr      (d_rs_addr),
        .i_tuse      (d_tuse_rs),
        .i_slot_e    (r_slot_e),
        .i_slot_m    (r_slot_m),
        .i_slot_w    (r_slot_w),
        .o_stall_req (w_stall_rs),
        .o_sel       (fwd_rs_d)
    );

    hazard_operand_check u_chk_rt_d (
        .i_addr      (d_rt_addr),
        .i_tuse      (d_tuse_rt),
        .i_slot_e    (r_slot_e),
        .i_slot_m    (r_slot_m),
        .i_slot_w    (r_slot_w),
        .o_stall_req (w_stall_rt),
        .o_sel       (fwd_rt_d)
    );

    // The E operand is consumed now (Tuse 0) and can only come from M or W.
    hazard_operand_check u_chk_rs_e (
        .i_addr      (r_e_rs_addr),
        .i_tuse      (2'd0),
        .i_slot_e    (SLOT_EMPTY),
        .i_slot_m    (r_slot_m),
        .i_slot_w    (r_slot_w),
        .o_stall_req (w_unused_e_rs_stall),
        .o_sel       (fwd_rs_e)
    );

    hazard_operand_check u_chk_rt_e (
        .i_addr      (r_e_rt_addr),
        .i_tuse      (2'd0),
        .i_slot_e    (SLOT_EMPTY),
        .i_slot_m    (r_slot_m),
        .i_slot_w    (r_slot_w),
        .o_stall_req (w_unused_e_rt_stall),
        .o_sel       (fwd_rt_e)
    );

endmodule
